// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the PC, runs a request/done handshake with a
// multi-cycle instruction memory, applies execute-stage redirects, stops at
// HALT and emits NOP bubbles whenever no instruction is delivered.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        imem_done,
    input  logic [15:0] imem_rdata,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    output logic [15:0] instr_f,
    output logic [15:0] pc_f,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] hold_buf_q, hold_buf_d;
    logic [15:0] sq_addr_q, sq_addr_d;

    logic [15:0] word;
    logic [15:0] pc_plus2;
    logic        deliver;
    logic        word_is_halt;

    // Candidate word, delivery qualifier and sequential PC
    always_comb begin
        word         = (state_q == HOLD) ? hold_buf_q : imem_rdata;
        pc_plus2     = pc_q + 16'd2;
        deliver      = !stall && !redirect &&
                       (((state_q == FETCH) && imem_done) || (state_q == HOLD));
        word_is_halt = (word[15:11] == 5'b00000);
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            hold_buf_q <= NOP_INSTR;
            sq_addr_q  <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hold_buf_q <= hold_buf_d;
            sq_addr_q  <= sq_addr_d;
        end
    end

    // Next-state logic; redirect outranks stall, done and halt
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_buf_d = hold_buf_q;
        sq_addr_d  = sq_addr_q;

        if (redirect) begin
            pc_d = redirect_pc;
            unique case (state_q)
                FETCH: begin
                    // An outstanding request must finish at its original
                    // address, so the old pc moves to sq_addr and pc is free.
                    if (!imem_done) begin
                        state_d   = SQUASH;
                        sq_addr_d = pc_q;
                    end
                end
                HOLD, HALTED: begin
                    state_d    = FETCH;
                    hold_buf_d = NOP_INSTR;
                end
                SQUASH: begin
                    if (imem_done) state_d = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end else if (deliver) begin
            if (word_is_halt) begin
                state_d = HALTED;
            end else begin
                pc_d    = pc_plus2;
                state_d = FETCH;
            end
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (imem_done) begin
                        hold_buf_d = imem_rdata;
                        state_d    = HOLD;
                    end
                end
                SQUASH: begin
                    if (imem_done) state_d = FETCH;
                end
                HOLD, HALTED: state_d = state_q;
                default:      state_d = FETCH;
            endcase
        end
    end

    // Outputs decoded from state plus the combinational delivery path
    always_comb begin
        imem_req  = (state_q == FETCH) || (state_q == SQUASH);
        imem_addr = (state_q == SQUASH) ? sq_addr_q : pc_q;
        instr_f   = deliver ? word : NOP_INSTR;
        pc_f      = deliver ? pc_plus2 : pc_q;
        halted    = (state_q == HALTED);
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized traffic
// against a variable-latency memory, all checked against a transaction-level
// model of the fetch stage.
module tb_fetch_unit;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst, stall, redirect, imem_done;
    logic [15:0] redirect_pc, imem_rdata;
    logic        imem_req, halted;
    logic [15:0] imem_addr, instr_f, pc_f;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0800)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_done(imem_done), .imem_rdata(imem_rdata),
        .imem_req(imem_req), .imem_addr(imem_addr), .instr_f(instr_f),
        .pc_f(pc_f), .halted(halted)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: pc, an optional waiting word, a stopped flag and an
    // optional abandoned request still owed a response.
    logic [15:0] m_pc, m_buf, m_drain_addr;
    bit          m_buf_valid, m_stopped, m_drain;

    // Outputs captured during the most recent step
    logic        o_req, o_halt;
    logic [15:0] o_addr, o_instr, o_pcf;

    logic [15:0] mem [256];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_pc = 16'h0000; m_buf = NOP; m_drain_addr = 16'h0000;
        m_buf_valid = 0; m_stopped = 0; m_drain = 0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_done = 1'b0; imem_rdata = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_req",   {15'b0, imem_req}, 16'h0001);
        chk("rst_addr",  imem_addr, 16'h0000);
        chk("rst_instr", instr_f, NOP);
        chk("rst_pcf",   pc_f, 16'h0000);
        chk("rst_halt",  {15'b0, halted}, 16'h0000);
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance model
    task automatic step(input logic s, input logic r, input logic [15:0] rp,
                        input logic d, input logic [15:0] rd);
        logic        e_req, avail, dlv;
        logic [15:0] e_addr, w, e_instr, e_pcf;
        @(negedge clk);
        stall = s; redirect = r; redirect_pc = rp; imem_done = d; imem_rdata = rd;
        e_req   = !m_buf_valid && !m_stopped;
        e_addr  = m_drain ? m_drain_addr : m_pc;
        avail   = m_buf_valid || (d && e_req && !m_drain);
        w       = m_buf_valid ? m_buf : rd;
        dlv     = avail && !s && !r;
        e_instr = dlv ? w : NOP;
        e_pcf   = dlv ? 16'(m_pc + 16'd2) : m_pc;
        #1;
        o_req = imem_req; o_addr = imem_addr; o_instr = instr_f; o_pcf = pc_f; o_halt = halted;
        chk("m_req",   {15'b0, imem_req}, {15'b0, e_req});
        if (e_req) chk("m_addr", imem_addr, e_addr);
        chk("m_instr", instr_f, e_instr);
        chk("m_pcf",   pc_f, e_pcf);
        chk("m_halt",  {15'b0, halted}, {15'b0, m_stopped});
        @(posedge clk);
        if (r) begin
            if (m_drain) begin
                if (d) m_drain = 0;
            end else if (e_req && !d) begin
                m_drain = 1; m_drain_addr = m_pc;
            end
            m_pc = rp; m_buf_valid = 0; m_stopped = 0;
        end else if (m_drain) begin
            if (d) m_drain = 0;
        end else if (dlv) begin
            m_buf_valid = 0;
            if (w[15:11] == 5'b00000) m_stopped = 1;
            else m_pc = 16'(m_pc + 16'd2);
        end else if (avail) begin
            m_buf_valid = 1; m_buf = w;
        end
    endtask

    initial begin
        bit          busy;
        int unsigned cnt;
        logic        rq, ds, rr, dd;
        logic [15:0] ad, rp, rd, w;

        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_done = 1'b0; imem_rdata = '0;
        model_reset();
        do_reset();

        // Zero-wait memory, back-to-back delivery
        step(0, 0, 16'h0, 1, 16'h4000);
        chk("t1_addr0", o_addr, 16'h0000); chk("t1_instr0", o_instr, 16'h4000); chk("t1_pcf0", o_pcf, 16'h0002);
        step(0, 0, 16'h0, 1, 16'h4100);
        chk("t1_addr1", o_addr, 16'h0002); chk("t1_instr1", o_instr, 16'h4100); chk("t1_pcf1", o_pcf, 16'h0004);
        step(0, 0, 16'h0, 1, 16'h4200);
        chk("t1_addr2", o_addr, 16'h0004); chk("t1_instr2", o_instr, 16'h4200); chk("t1_pcf2", o_pcf, 16'h0006);

        // Slow memory, stall when data arrives
        step(0, 0, 16'h0, 0, 16'h0);
        step(0, 0, 16'h0, 0, 16'h0);
        chk("t2_addr", o_addr, 16'h0006);
        step(1, 0, 16'h0, 1, 16'hC0DE);
        chk("t2_stall_instr", o_instr, NOP);
        step(1, 0, 16'h0, 0, 16'h0);
        chk("t2_hold_req", {15'b0, o_req}, 16'h0000); chk("t2_hold_instr", o_instr, NOP);
        step(0, 0, 16'h0, 0, 16'h0);
        chk("t2_rel_instr", o_instr, 16'hC0DE); chk("t2_rel_pcf", o_pcf, 16'h0008);
        step(0, 0, 16'h0, 1, 16'h4444);
        chk("t2_next_addr", o_addr, 16'h0008);

        // Redirect during a pending request
        step(0, 0, 16'h0, 0, 16'h0);
        chk("t3_addr", o_addr, 16'h000A);
        step(0, 1, 16'h0040, 0, 16'h0);
        chk("t3_redir_instr", o_instr, NOP); chk("t3_redir_addr", o_addr, 16'h000A);
        step(0, 0, 16'h0, 0, 16'h0);
        chk("t3_sq_addr", o_addr, 16'h000A); chk("t3_sq_req", {15'b0, o_req}, 16'h0001);
        step(0, 0, 16'h0, 1, 16'hDEAD);
        chk("t3_sq_drop", o_instr, NOP); chk("t3_sq_addr2", o_addr, 16'h000A);
        step(0, 0, 16'h0, 0, 16'h0);
        chk("t3_new_addr", o_addr, 16'h0040);

        // HALT at 0x20, then recovery by redirect
        step(0, 1, 16'h0020, 1, 16'hBEEF);
        chk("t4_drop", o_instr, NOP);
        step(0, 0, 16'h0, 1, 16'h0000);
        chk("t4_addr", o_addr, 16'h0020); chk("t4_instr", o_instr, 16'h0000); chk("t4_pcf", o_pcf, 16'h0022);
        step(0, 0, 16'h0, 0, 16'h0);
        chk("t4_halted", {15'b0, o_halt}, 16'h0001); chk("t4_req", {15'b0, o_req}, 16'h0000); chk("t4_nop", o_instr, NOP);
        step(0, 0, 16'h0, 1, 16'h4000);
        chk("t4_ignore", o_instr, NOP);
        step(0, 1, 16'h0100, 0, 16'h0);
        chk("t4_redir_nop", o_instr, NOP);
        step(0, 0, 16'h0, 0, 16'h0);
        chk("t4_unhalt", {15'b0, o_halt}, 16'h0000); chk("t4_new_addr", o_addr, 16'h0100);

        // PC wrap at 0xFFFE
        step(0, 1, 16'hFFFE, 0, 16'h0);
        step(0, 0, 16'h0, 1, 16'h1234);
        chk("t5_sq_addr", o_addr, 16'h0100); chk("t5_sq_nop", o_instr, NOP);
        step(0, 0, 16'h0, 1, 16'h4000);
        chk("t5_addr", o_addr, 16'hFFFE); chk("t5_pcf", o_pcf, 16'h0000);
        step(0, 0, 16'h0, 0, 16'h0);
        chk("t5_wrap_addr", o_addr, 16'h0000);

        // Redirect + stall + done together; then reset while in HOLD
        step(1, 1, 16'h0080, 1, 16'h5555);
        chk("t6_nop", o_instr, NOP);
        step(0, 0, 16'h0, 0, 16'h0);
        chk("t6_addr", o_addr, 16'h0080);
        step(1, 0, 16'h0, 1, 16'h6666);
        step(1, 0, 16'h0, 0, 16'h0);
        chk("t6_hold_req", {15'b0, o_req}, 16'h0000);
        do_reset();

        // Randomized traffic with a variable-latency memory
        for (int i = 0; i < 256; i++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 11) == 0) w[15:11] = 5'b00000;
            else if (w[15:11] == 5'b00000) w[15:11] = 5'b00001;
            mem[i] = w;
        end
        busy = 0; cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                busy = 0;
            end
            rq = !m_buf_valid && !m_stopped;
            ad = m_drain ? m_drain_addr : m_pc;
            dd = 1'b0; rd = 16'(~ad);
            if (rq) begin
                if (!busy) begin
                    busy = 1; cnt = $urandom_range(0, 3);
                end
                if (cnt == 0) begin
                    dd = 1'b1; rd = mem[ad[8:1]]; busy = 0;
                end else begin
                    cnt--;
                end
            end else begin
                busy = 0;
            end
            ds = ($urandom_range(0, 3) == 0);
            rr = ($urandom_range(0, 9) == 0);
            rp = 16'($urandom);
            if ($urandom_range(0, 15) != 0) rp[0] = 1'b0;
            step(ds, rr, rp, dd, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage. Produces `instr_f`/`pc_f` for the IF/ID pipeline register and honours the same `stall` that register uses.
- Owns the PC and runs a request/done handshake with a multi-cycle instruction memory.
- Applies branch/jump redirects from execute and stops fetching at HALT.
- Emits NOP bubbles whenever no valid instruction is available.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0800, encoding driven on `instr_f` when no instruction is delivered (WISC NOP, opcode 00001).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset (rst==0 at a rising edge resets).
- stall  input  1  hazard hold; same signal that freezes IF/ID.
- redirect  input  1  flush and load new PC (branch taken/jump).
- redirect_pc  input  16  target PC for redirect.
- imem_done  input  1  memory response valid this cycle.
- imem_rdata  input  16  instruction word, valid when imem_done=1.
- imem_req  output  1  fetch request; held high until imem_done.
- imem_addr  output  16  fetch address; stable while imem_req=1.
- instr_f  output  16  instruction to IF/ID.
- pc_f  output  16  PC+2 of the delivered instruction.
- halted  output  1  fetch stopped on HALT.

Behaviour:
- Registers: `pc`, `state`, `hold_buf[15:0]`. Reset values: pc=RESET_PC, state=FETCH, hold_buf=NOP_INSTR.
- Reset output values: imem_req=1, imem_addr=RESET_PC, instr_f=NOP_INSTR, pc_f=RESET_PC, halted=0. Reset overrides all inputs, including mid-transaction; memory must tolerate an abandoned request.
- States:
  - FETCH: imem_req=1, imem_addr=pc.
  - HOLD: imem_req=0; hold_buf contains a fetched word.
  - SQUASH: imem_req=1, imem_addr=pc (old); response will be discarded.
  - HALTED: imem_req=0, halted=1.
- deliver = (FETCH & imem_done & !stall & !redirect) | (HOLD & !stall & !redirect).
  - On deliver: instr_f = word (imem_rdata in FETCH, hold_buf in HOLD); pc_f = pc+2 (combinational, same cycle).
  - Otherwise: instr_f=NOP_INSTR, pc_f=pc.
- On deliver with word[15:11]!=5'b00000: pc <= pc+2, modulo 2^16 (16'hFFFE wraps to 16'h0000); state <= FETCH.
- On deliver with word[15:11]==5'b00000 (HALT): pc unchanged; state <= HALTED. The HALT word itself is delivered.
- FETCH & imem_done & stall & !redirect: hold_buf <= imem_rdata; state <= HOLD. Latency is zero cycles from done to instr_f unless stalled.
- FETCH & !imem_done: remain in FETCH. imem_done may arrive in the first request cycle.
- Redirect has highest priority (over stall, done and halt):
  - pc <= redirect_pc; instr_f=NOP_INSTR that cycle.
  - FETCH & !imem_done: state <= SQUASH.
  - FETCH with imem_done: response dropped; state <= FETCH.
  - HOLD or HALTED: hold_buf discarded; state <= FETCH. An older branch cancels a speculative HALT.
- SQUASH: keep requesting the old address.
  - On imem_done: discard data; state <= FETCH (new pc).
  - A further redirect in SQUASH updates pc only.
- imem_addr must not change while imem_req=1 and imem_done=0. This is why the squash address is retained in a separate register (`sq_addr`) and pc is free to take the redirect target.
- redirect_pc[0]=1: loaded as given; not checked.
- halted=1 only in HALTED; cleared only by rst or redirect.

Test Plan:
1. Reset, zero-wait memory returning 16'h4000, 16'h4100, 16'h4200 -> imem_addr 0,2,4 on consecutive cycles; pc_f 2,4,6; instr_f matches each cycle.
2. 3-cycle memory, stall=1 when done arrives with 16'hC0DE at pc=6 -> instr_f=NOP and imem_req=0 while stalled; on stall release, instr_f=16'hC0DE, pc_f=8, next request to 8.
3. Pending request at pc=10, redirect to 16'h0040 before done -> imem_addr stays 10 until done, that data never appears on instr_f, next imem_addr=16'h0040.
4. Memory returns 16'h0000 at pc=16'h0020 -> instr_f=16'h0000 and pc_f=16'h0022 for one cycle, then halted=1, imem_req=0, instr_f=NOP; later redirect to 16'h0100 -> halted=0, fetch at 16'h0100.
5. pc=16'hFFFE, delivered non-HALT -> pc_f=16'h0000 and next imem_addr=16'h0000.
6. Redirect, stall and imem_done all high in one cycle -> instr_f=NOP, data dropped, next imem_addr=redirect_pc. Separately, rst=0 while in HOLD -> all outputs at reset values on the next cycle.
